// File: rtl/cnt_mon.sv
// Passive reference-model checker for an up/down counter; flags count/rollover mismatches.
// Latency: err pulses the cycle after the sampling edge; no backpressure (observes only).
module cnt_mon #(
   parameter int WIDTH = 4,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             chk_en,
   input  logic             clr,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load,
   input  logic             down,
   input  logic [WIDTH-1:0] count,
   input  logic             rollover,
   output logic             err,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] roll_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_act
);

   localparam logic [0:0]       SYNC    = 1'b0;
   localparam logic [0:0]       CHECK   = 1'b1;
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic [0:0]       state;
   logic [WIDTH-1:0] exp_q;
   logic [WIDTH-1:0] cmp_exp;
   logic [WIDTH-1:0] exp_nxt;
   logic             exp_roll;
   logic             cnt_mis;
   logic             roll_mis;
   logic             mis;

   // In SYNC the counter has just left reset, so the reference value is 0 and
   // the model still advances so CHECK starts aligned.
   always_comb begin
      cmp_exp  = (state == CHECK) ? exp_q : '0;
      exp_roll = (state == CHECK) && !load_en &&
                 ((!down && (&exp_q)) || (down && (exp_q == '0)));
      if (load_en)   exp_nxt = load;
      else if (down) exp_nxt = cmp_exp - ONE;
      else           exp_nxt = cmp_exp + ONE;
      cnt_mis  = (count != cmp_exp);
      roll_mis = (state == CHECK) && (rollover != exp_roll);
      mis      = chk_en && (cnt_mis || roll_mis);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= SYNC;
         exp_q <= '0;
      end else begin
         state <= CHECK;
         exp_q <= exp_nxt;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         roll_cnt   <= '0;
         first_exp  <= '0;
         first_act  <= '0;
      end else if (clr) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         roll_cnt   <= '0;
         first_exp  <= '0;
         first_act  <= '0;
      end else begin
         err <= mis;
         if (mis && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + ERR_ONE;
         if (mis && !err_sticky) begin
            err_sticky <= 1'b1;
            first_exp  <= cmp_exp;
            first_act  <= count;
         end
         if (exp_roll && (roll_cnt != ERR_MAX)) roll_cnt <= roll_cnt + ERR_ONE;
      end
   end

endmodule
